vec_lane_sequencer: RTL and testbench

- Multi-cycle scheduler that time-multiplexes an M-element vector ALU operation over LANES physical lane ALUs.
- Sits in the execute stage alongside the vector datapath. Accepts one vector op, issues it in ceil(M/LANES) beats to an external combinational lane ALU, and assembles the M*N result.
- Stalls the pipeline (EX/MEM buffer enable) while busy.
- Scalar ops bypass this block entirely.

---
 rtl/vseq_pkg.sv | 25 ++
 rtl/vseq_lane_slice.sv | 38 +++
 rtl/vec_lane_sequencer.sv | 141 ++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vseq_pkg.sv
// Shared types and sizing helpers for the vector lane sequencer.
// Beat count is ceil(M/LANES); the beat counter carries one spare bit.
package vseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vseqState_t;

    localparam int DEF_N     = 24;
    localparam int DEF_M     = 6;
    localparam int DEF_LANES = 2;

    function automatic int beats(input int m, input int lanes);
        return (m + lanes - 1) / lanes;
    endfunction

    function automatic int beatWidth(input int m, input int lanes);
        return $clog2(beats(m, lanes)) + 1;
    endfunction

    localparam int DEF_BEAT_W = beatWidth(DEF_M, DEF_LANES);

endpackage

// File: rtl/vseq_lane_slice.sv
// Combinational beat slicer: picks the LANES elements for the current beat
// (zero for lanes past element M-1) and builds the result write mask.
module vseq_lane_slice
    import vseq_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int M      = DEF_M,
    parameter int LANES  = DEF_LANES,
    parameter int BEAT_W = DEF_BEAT_W
) (
    input  logic [BEAT_W-1:0]  beat,
    input  logic [M*N-1:0]     vecA,
    input  logic [M*N-1:0]     vecB,
    input  logic [LANES*N-1:0] laneResult,
    output logic [LANES*N-1:0] laneA,
    output logic [LANES*N-1:0] laneB,
    output logic [M-1:0]       wrMask,
    output logic [M*N-1:0]     wrData
);

    // Element i always maps to lane i%LANES in beat i/LANES, so every index
    // below is a constant after unrolling; unused lanes simply stay zero.
    always_comb begin
        laneA  = '0;
        laneB  = '0;
        wrMask = '0;
        wrData = '0;
        for (int i = 0; i < M; i++) begin
            if (beat == BEAT_W'(i / LANES)) begin
                laneA[(i % LANES)*N +: N] = vecA[i*N +: N];
                laneB[(i % LANES)*N +: N] = vecB[i*N +: N];
                wrMask[i]                 = 1'b1;
            end
            wrData[i*N +: N] = laneResult[(i % LANES)*N +: N];
        end
    end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Time-multiplexes one M-element vector op over LANES lane ALUs in ceil(M/LANES) beats.
// Optional stall-cycle performance counter enabled by defining VSEQ_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start; accepts and captures operands
// RUN   | issuing one beat per cycle to the lane ALUs
// DONE  | one-cycle done pulse, result stable, pipeline released
module vec_lane_sequencer
    import vseq_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int LANES = DEF_LANES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [3:0]         aluControl,
    input  logic [M*N-1:0]     opA,
    input  logic [M*N-1:0]     opB,
    output logic [LANES*N-1:0] laneA,
    output logic [LANES*N-1:0] laneB,
    output logic [3:0]         laneOp,
    output logic               laneValid,
    input  logic [LANES*N-1:0] laneResult,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [M*N-1:0]     result,
    output logic [31:0]        stallCycles
);

    localparam int NUM_BEATS = beats(M, LANES);
    localparam int BEAT_W    = beatWidth(M, LANES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    vseqState_t state, stateNext;

    logic [BEAT_W-1:0]  beat;
    logic [M*N-1:0]     capA;
    logic [M*N-1:0]     capB;
    logic [3:0]         capOp;
    logic               accept;
    logic               lastBeat;
    logic [LANES*N-1:0] sliceA;
    logic [LANES*N-1:0] sliceB;
    logic [M-1:0]       wrMask;
    logic [M*N-1:0]     wrData;

    vseq_lane_slice #(
        .N      (N),
        .M      (M),
        .LANES  (LANES),
        .BEAT_W (BEAT_W)
    ) u_slice (
        .beat       (beat),
        .vecA       (capA),
        .vecB       (capB),
        .laneResult (laneResult),
        .laneA      (sliceA),
        .laneB      (sliceB),
        .wrMask     (wrMask),
        .wrData     (wrData)
    );

    assign lastBeat = (beat == LAST_BEAT);

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastBeat) stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            capA   <= '0;
            capB   <= '0;
            capOp  <= '0;
            result <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                capA  <= opA;
                capB  <= opB;
                capOp <= aluControl;
                beat  <= '0;
            end else if (flush || state != RUN || lastBeat) begin
                beat <= '0;
            end else begin
                beat <= beat + 1'b1;
            end
            // A flushed beat is not committed; earlier beats stay as written.
            if (state == RUN && !flush) begin
                for (int i = 0; i < M; i++) begin
                    if (wrMask[i]) result[i*N +: N] <= wrData[i*N +: N];
                end
            end
        end
    end

    assign laneValid = (state == RUN);
    assign laneA     = laneValid ? sliceA : '0;
    assign laneB     = laneValid ? sliceB : '0;
    assign laneOp    = capOp;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign stall     = accept || (state == RUN);

`ifdef VSEQ_PERF_CNT_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (stall && stallCnt != '1) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stallCycles = stallCnt;
`else
    assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Scoreboard bench for vec_lane_sequencer: a 6-element instance for timing,
// flush, reset and back-to-back cases, and a 5-element instance for partial beats.
`timescale 1ns/1ps
module tb_vec_lane_sequencer;
    import vseq_pkg::*;

    localparam int N  = 24;
    localparam int M0 = 6;
    localparam int M1 = 5;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic              start0, flush0;
    logic [3:0]        ctl0, laneOp0;
    logic [M0*N-1:0]   opA0, opB0, result0;
    logic [L*N-1:0]    laneA0, laneB0, laneRes0;
    logic              laneValid0, stall0, busy0, done0;
    logic [31:0]       stallCycles0;

    logic              start1, flush1;
    logic [3:0]        ctl1, laneOp1;
    logic [M1*N-1:0]   opA1, opB1, result1;
    logic [L*N-1:0]    laneA1, laneB1, laneRes1;
    logic              laneValid1, stall1, busy1, done1;
    logic [31:0]       stallCycles1;

    vec_lane_sequencer #(.N(N), .M(M0), .LANES(L)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .flush(flush0), .aluControl(ctl0),
        .opA(opA0), .opB(opB0), .laneA(laneA0), .laneB(laneB0), .laneOp(laneOp0),
        .laneValid(laneValid0), .laneResult(laneRes0), .stall(stall0), .busy(busy0),
        .done(done0), .result(result0), .stallCycles(stallCycles0)
    );

    vec_lane_sequencer #(.N(N), .M(M1), .LANES(L)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .flush(flush1), .aluControl(ctl1),
        .opA(opA1), .opB(opB1), .laneA(laneA1), .laneB(laneB1), .laneOp(laneOp1),
        .laneValid(laneValid1), .laneResult(laneRes1), .stall(stall1), .busy(busy1),
        .done(done1), .result(result1), .stallCycles(stallCycles1)
    );

    function automatic logic [N-1:0] aluRef(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        laneRes0 = '0;
        laneRes1 = '0;
        for (int k = 0; k < L; k++) begin
            laneRes0[k*N +: N] = aluRef(laneOp0, laneA0[k*N +: N], laneB0[k*N +: N]);
            laneRes1[k*N +: N] = aluRef(laneOp1, laneA1[k*N +: N], laneB1[k*N +: N]);
        end
    end

    function automatic logic [M0*N-1:0] vecRef(input logic [3:0] op, input logic [M0*N-1:0] a,
                                               input logic [M0*N-1:0] b);
        logic [M0*N-1:0] r;
        r = '0;
        for (int i = 0; i < M0; i++) r[i*N +: N] = aluRef(op, a[i*N +: N], b[i*N +: N]);
        return r;
    endfunction

    function automatic logic [M0*N-1:0] randVec();
        logic [M0*N-1:0] v;
        v = '0;
        for (int i = 0; i < M0; i++) v[i*N +: N] = N'($urandom);
        return v;
    endfunction

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkVal(input string tag, input logic [191:0] got, input logic [191:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [M0*N-1:0] res;
        int              cyc;
    } exp_t;
    exp_t expQ[$];

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!rst && done0) begin
            if (expQ.size() == 0) begin
                checkVal("spurious_done", done0, 1'b0);
            end else begin
                e = expQ.pop_front();
                checkVal("done_cycle", cyc, e.cyc);
                checkVal("result", result0, e.res);
            end
        end
    end

    task automatic accept0(input logic [3:0] op, input logic [M0*N-1:0] a, input logic [M0*N-1:0] b);
        @(negedge clk);
        start0 = 1'b1; ctl0 = op; opA0 = a; opB0 = b;
        #1;
        checkVal("stall_on_accept", stall0, 1'b1);
        expQ.push_back('{res: vecRef(op, a, b), cyc: cyc + 4});
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #3;
        checkVal("drain_pending", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [M0*N-1:0] a, b, basicExp;
        logic [M1*N-1:0] a1, exp1;
        int stallCnt, accCyc, beatCnt, doneCyc;
        logic [31:0] perfExp0, perfExp1;

        rst = 1'b1;
        start0 = 0; flush0 = 0; ctl0 = 0; opA0 = '0; opB0 = '0;
        start1 = 0; flush1 = 0; ctl1 = 0; opA1 = '0; opB1 = '0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("rst_result", result0, '0);
        checkVal("rst_done", done0, 1'b0);
        checkVal("rst_busy", busy0, 1'b0);
        checkVal("rst_laneValid", laneValid0, 1'b0);
        checkVal("rst_laneA", laneA0, '0);
        checkVal("rst_laneB", laneB0, '0);
        checkVal("rst_stallCycles", stallCycles0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // basic op: elements 1..6 plus 0x10
        for (int i = 0; i < M0; i++) begin
            a[i*N +: N]        = N'(i + 1);
            b[i*N +: N]        = 24'h000010;
            basicExp[i*N +: N] = N'(24'h11 + i);
        end
        @(negedge clk);
        start0 = 1'b1; ctl0 = 4'd0; opA0 = a; opB0 = b;
        #1;
        expQ.push_back('{res: vecRef(4'd0, a, b), cyc: cyc + 4});
        stallCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (stall0) stallCnt++;
            @(negedge clk);
            start0 = 1'b0;
            #1;
        end
        checkVal("basic_stall_cycles", stallCnt, 4);
        drain(10);
        checkVal("basic_result_const", result0, basicExp);

        // flush together with start in IDLE must not accept
        @(negedge clk);
        start0 = 1'b1; flush0 = 1'b1;
        #1;
        checkVal("flush_start_stall", stall0, 1'b0);
        @(negedge clk);
        start0 = 1'b0; flush0 = 1'b0;
        #1;
        checkVal("flush_start_busy", busy0, 1'b0);

        // flush during beat 1
        @(negedge clk);
        start0 = 1'b1; ctl0 = 4'd1; opA0 = randVec(); opB0 = randVec();
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        flush0 = 1'b1;
        #1;
        checkVal("flush_beat1_valid", laneValid0, 1'b1);
        @(negedge clk);
        flush0 = 1'b0;
        #1;
        checkVal("flush_busy", busy0, 1'b0);
        checkVal("flush_stall", stall0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkVal("flush_no_done", done0, 1'b0);
        end
        accept0(4'd2, randVec(), randVec());
        drain(10);

        // reset during beat 2
        @(negedge clk);
        start0 = 1'b1; ctl0 = 4'd0; opA0 = randVec(); opB0 = randVec();
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkVal("rstmid_result", result0, '0);
        checkVal("rstmid_done", done0, 1'b0);
        checkVal("rstmid_busy", busy0, 1'b0);
        checkVal("rstmid_laneValid", laneValid0, 1'b0);
        rst = 1'b0;

        // back-to-back with start held; operands change every cycle
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            start0 = 1'b1;
            ctl0 = 4'(j % 4);
            opA0 = randVec();
            opB0 = randVec();
            #1;
            if (j == 0 || j == 5) expQ.push_back('{res: vecRef(ctl0, opA0, opB0), cyc: cyc + 4});
            checkVal("b2b_stall", stall0, (j % 5) != 4);
        end
        @(negedge clk);
        start0 = 1'b0;
        drain(12);
`ifdef VSEQ_PERF_CNT_EN
        perfExp0 = 32'd8;
        perfExp1 = 32'd4;
`else
        perfExp0 = 32'd0;
        perfExp1 = 32'd0;
`endif
        checkVal("perf_stallCycles", stallCycles0, perfExp0);

        // partial last beat on the 5-element instance
        for (int i = 0; i < M1; i++) begin
            a1[i*N +: N]   = 24'hFFFFFF;
            exp1[i*N +: N] = 24'hFFFFFE;
        end
        @(negedge clk);
        start1 = 1'b1; ctl1 = 4'd0; opA1 = a1; opB1 = a1;
        accCyc = cyc;
        beatCnt = 0;
        doneCyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            #1;
            if (laneValid1) begin
                if (beatCnt == 2) begin
                    checkVal("partial_lane1A", laneA1[N +: N], '0);
                    checkVal("partial_lane1B", laneB1[N +: N], '0);
                    checkVal("partial_lane0A", laneA1[0 +: N], 24'hFFFFFF);
                end
                beatCnt++;
            end
            if (done1 && doneCyc < 0) begin
                doneCyc = cyc;
                checkVal("partial_result", result1, exp1);
            end
        end
        checkVal("partial_beats", beatCnt, 3);
        checkVal("partial_done_cycle", doneCyc, accCyc + 4);
        checkVal("partial_stallCycles", stallCycles1, perfExp1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
